rdout_stream_tx: RTL and testbench

//   Consumer end of the readout result interface (est / W_out / data_valid / addr) under esn_top.

---
 rtl/esn_rdout_pkg.sv | 20 ++
 rtl/rdout_stream_tx_if.sv | 16 +
 rtl/rdout_tx_fifo.sv | 51 +++++
 rtl/rdout_stream_tx.sv | 148 ++++++++++++++
 tb/tb_rdout_stream_tx.sv | 287 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/esn_rdout_pkg.sv
// esn_rdout_pkg: stream tag codes, dump header magic and transmitter FSM states
// shared by the readout stream transmitter and its FIFO.
package esn_rdout_pkg;

    localparam logic [1:0] TAG_EST = 2'b00;
    localparam logic [1:0] TAG_HDR = 2'b01;
    localparam logic [1:0] TAG_W   = 2'b10;
    localparam logic [1:0] TAG_CK  = 2'b11;

    localparam logic [7:0] HDR_MAGIC = 8'hA5;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_EST,
        ST_DUMP_HDR,
        ST_DUMP_W,
        ST_DUMP_CK
    } state_t;

endpackage

// File: rtl/rdout_stream_tx_if.sv
// rdout_stream_tx_if: tagged 32-bit valid/ready stream from the readout transmitter
// towards the host link.
interface rdout_stream_tx_if #(
    parameter int DW = 32,
    parameter int AW = 6
);
    logic [DW-1:0] m_data;
    logic [AW-1:0] m_addr;
    logic [1:0]    m_tag;
    logic          m_last;
    logic          m_valid;
    logic          m_ready;

    modport master (output m_data, m_addr, m_tag, m_last, m_valid, input m_ready);
    modport slave  (input m_data, m_addr, m_tag, m_last, m_valid, output m_ready);
endinterface

// File: rtl/rdout_tx_fifo.sv
// rdout_tx_fifo: synchronous FIFO with full/empty/level; a push on a full FIFO is
// accepted when a pop happens in the same cycle.
module rdout_tx_fifo #(
    parameter int W     = 38,
    parameter int DEPTH = 8,
    parameter int PW    = $clog2(DEPTH),
    parameter int LW    = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst_N,
    input  logic          push,
    input  logic [W-1:0]  wdata,
    input  logic          pop,
    output logic [W-1:0]  rdata,
    output logic          full,
    output logic          empty,
    output logic [LW-1:0] level
);
    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [LW-1:0] count;
    logic          push_ok, pop_ok;

    assign full    = (count == LW'(DEPTH));
    assign empty   = (count == '0);
    assign level   = count;
    assign rdata   = mem[rd_ptr];
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk) begin
        if (!rst_N) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + PW'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + PW'(1);
            count <= count + LW'(push_ok) - LW'(pop_ok);
        end
    end

    // NOTE: storage is deliberately not reset; the pointers alone define validity,
    // and leaving the array reset-free lets it map onto plain RAM/flops.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/rdout_stream_tx.sv
// rdout_stream_tx: buffers readout estimates and snapshots weight dumps onto one tagged
// valid/ready stream. Define RDOUT_TX_CKSUM_EN to append an XOR checksum word to dumps.
module rdout_stream_tx
    import esn_rdout_pkg::*;
#(
    parameter int N_W        = 8,
    parameter int DW         = 32,
    parameter int AW         = 6,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                clk,
    input  logic                rst_N,
    input  logic                ce,
    input  logic                data_valid,
    input  logic [DW-1:0]       est,
    input  logic [AW-1:0]       addr,
    input  logic [N_W*DW-1:0]   W_out,
    input  logic                dump_req,
    rdout_stream_tx_if.master   m,
    output logic                busy,
    output logic                overflow
);
    localparam int IW = (N_W > 1) ? $clog2(N_W) : 1;
    localparam int LW = $clog2(FIFO_DEPTH) + 1;

    state_t              state, state_nxt;
    logic                pending, snap;
    logic [AW-1:0]       last_addr, shadow_addr;
    logic [N_W*DW-1:0]   shadow_w;
    logic [IW-1:0]       w_idx;
    logic                w_last;

    logic                push_req, fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [AW+DW-1:0]    fifo_rdata;
    logic [LW-1:0]       fifo_level;

    assign push_req  = data_valid && ce;
    assign fifo_pop  = (state == ST_EST) && m.m_ready;
    assign fifo_push = push_req && (!fifo_full || fifo_pop);
    assign w_last    = (w_idx == IW'(N_W - 1));
    assign busy      = (state != ST_IDLE);

    rdout_tx_fifo #(.W(AW + DW), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .rst_N (rst_N),
        .push  (fifo_push),
        .wdata ({addr, est}),
        .pop   (fifo_pop),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (fifo_level)
    );

    always_comb begin
        assert (fifo_empty == (fifo_level == '0));
    end

`ifdef RDOUT_TX_CKSUM_EN
    logic [DW-1:0] cksum;
    always_comb begin
        cksum = '0;
        for (int k = 0; k < N_W; k++) cksum = cksum ^ shadow_w[k*DW +: DW];
    end
`endif

    // NOTE: every output of this block gets a default first, so no path can
    // leave a signal unassigned and infer a latch.
    always_comb begin
        state_nxt = state;
        snap      = 1'b0;
        m.m_valid = 1'b0;
        m.m_data  = '0;
        m.m_addr  = '0;
        m.m_tag   = TAG_EST;
        m.m_last  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (pending) begin
                    snap      = 1'b1;
                    state_nxt = ST_DUMP_HDR;
                end else if (!fifo_empty) begin
                    state_nxt = ST_EST;
                end
            end
            ST_EST: begin
                m.m_valid = 1'b1;
                m.m_data  = fifo_rdata[DW-1:0];
                m.m_addr  = fifo_rdata[AW+DW-1:DW];
                m.m_last  = 1'b1;
                if (m.m_ready) state_nxt = ST_IDLE;
            end
            ST_DUMP_HDR: begin
                m.m_valid = 1'b1;
                m.m_data  = DW'({HDR_MAGIC, 8'(N_W), 16'h0});
                m.m_addr  = shadow_addr;
                m.m_tag   = TAG_HDR;
                if (m.m_ready) state_nxt = ST_DUMP_W;
            end
            ST_DUMP_W: begin
                m.m_valid = 1'b1;
                m.m_data  = shadow_w[w_idx*DW +: DW];
                m.m_tag   = TAG_W;
`ifdef RDOUT_TX_CKSUM_EN
                if (m.m_ready && w_last) state_nxt = ST_DUMP_CK;
`else
                m.m_last  = w_last;
                if (m.m_ready && w_last) state_nxt = ST_IDLE;
`endif
            end
`ifdef RDOUT_TX_CKSUM_EN
            ST_DUMP_CK: begin
                m.m_valid = 1'b1;
                m.m_data  = cksum;
                m.m_tag   = TAG_CK;
                m.m_last  = 1'b1;
                if (m.m_ready) state_nxt = ST_IDLE;
            end
`endif
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_N) begin
            state       <= ST_IDLE;
            pending     <= 1'b0;
            overflow    <= 1'b0;
            last_addr   <= '0;
            shadow_addr <= '0;
            w_idx       <= '0;
        end else begin
            state   <= state_nxt;
            // A request arriving on the snapshot cycle stays pending for the next frame.
            pending <= dump_req || (pending && !snap);
            if (push_req && !fifo_push) overflow <= 1'b1;
            if (fifo_push) last_addr <= addr;
            if (snap) shadow_addr <= last_addr;
            if (state == ST_DUMP_W && m.m_ready) w_idx <= w_last ? '0 : w_idx + IW'(1);
        end
    end

    // Weight shadow is pure data: only read while a dump frame is in flight.
    always_ff @(posedge clk) begin
        if (snap) shadow_w <= W_out;
    end

endmodule

// File: tb/tb_rdout_stream_tx.sv
// tb_rdout_stream_tx: directed scenarios plus randomized traffic checked cycle by cycle
// against a queue-based transaction model of the readout stream transmitter.
module tb_rdout_stream_tx;
    localparam int N_W   = 8;
    localparam int DW    = 32;
    localparam int AW    = 6;
    localparam int DEPTH = 8;
`ifdef RDOUT_TX_CKSUM_EN
    localparam bit CK_EN = 1'b1;
`else
    localparam bit CK_EN = 1'b0;
`endif
    localparam int FRAME_LEN = 1 + N_W + (CK_EN ? 1 : 0);

    logic                clk = 1'b0;
    logic                rst_N, ce, data_valid, dump_req, busy, overflow;
    logic [DW-1:0]       est;
    logic [AW-1:0]       addr;
    logic [N_W*DW-1:0]   W_out;

    rdout_stream_tx_if #(.DW(DW), .AW(AW)) s ();

    rdout_stream_tx #(.N_W(N_W), .DW(DW), .AW(AW), .FIFO_DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst_N      (rst_N),
        .ce         (ce),
        .data_valid (data_valid),
        .est        (est),
        .addr       (addr),
        .W_out      (W_out),
        .dump_req   (dump_req),
        .m          (s),
        .busy       (busy),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [DW-1:0] data;
        logic [AW-1:0] addr;
        logic [1:0]    tag;
        logic          last;
    } word_t;

    // Reference model: pending words of the frame in flight, buffered estimates, flags.
    word_t              frame_q[$];
    logic [AW+DW-1:0]   est_q[$];
    bit                 pend, ovf, was_idle, est_pop, dump_start;
    int                 sz;
    logic [AW-1:0]      last_a;
    logic [DW-1:0]      ck;

    word_t              cap_q[$];
    int                 cap_cyc[$];
    int                 cyc = 0;
    bit                 chk_en = 1'b0;
    int                 n_checks = 0;
    int                 n_pass = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    endtask

    always @(posedge clk) begin
        cyc = cyc + 1;
        if (s.m_valid && s.m_ready) begin
            cap_q.push_back(word_t'{s.m_data, s.m_addr, s.m_tag, s.m_last});
            cap_cyc.push_back(cyc);
        end
        if (!rst_N) begin
            frame_q.delete();
            est_q.delete();
            pend   = 1'b0;
            ovf    = 1'b0;
            last_a = '0;
        end else begin
            was_idle   = (frame_q.size() == 0);
            sz         = est_q.size();
            est_pop    = 1'b0;
            dump_start = 1'b0;
            if (!was_idle && s.m_ready) begin
                est_pop = (frame_q[0].tag == 2'b00);
                void'(frame_q.pop_front());
            end
            if (was_idle) begin
                if (pend) begin
                    dump_start = 1'b1;
                    frame_q.push_back(word_t'{{8'hA5, 8'(N_W), 16'h0}, last_a, 2'b01, 1'b0});
                    ck = '0;
                    for (int k = 0; k < N_W; k++) begin
                        frame_q.push_back(word_t'{W_out[k*DW +: DW], {AW{1'b0}}, 2'b10,
                                                  (k == N_W - 1) && !CK_EN});
                        ck = ck ^ W_out[k*DW +: DW];
                    end
                    if (CK_EN) frame_q.push_back(word_t'{ck, {AW{1'b0}}, 2'b11, 1'b1});
                end else if (sz > 0) begin
                    frame_q.push_back(word_t'{est_q[0][DW-1:0], est_q[0][AW+DW-1:DW], 2'b00, 1'b1});
                end
            end
            if (data_valid && ce) begin
                if (sz < DEPTH || est_pop) begin
                    est_q.push_back({addr, est});
                    last_a = addr;
                end else begin
                    ovf = 1'b1;
                end
            end
            if (est_pop) void'(est_q.pop_front());
            pend = dump_req || (pend && !dump_start);
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("m_valid", s.m_valid, frame_q.size() != 0);
            check("busy", busy, frame_q.size() != 0);
            check("overflow", overflow, ovf);
            if (frame_q.size() != 0) begin
                check("m_data", s.m_data, frame_q[0].data);
                check("m_addr", s.m_addr, frame_q[0].addr);
                check("m_tag", s.m_tag, frame_q[0].tag);
                check("m_last", s.m_last, frame_q[0].last);
            end
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic clear_cap();
        cap_q.delete();
        cap_cyc.delete();
    endtask

    task automatic set_ramp();
        for (int k = 0; k < N_W; k++) W_out[k*DW +: DW] = DW'(k + 1);
    endtask

    initial begin
        int dv_cyc;
        rst_N = 1'b0; ce = 1'b1; data_valid = 1'b0; dump_req = 1'b0;
        est = '0; addr = '0; W_out = '0; s.m_ready = 1'b0;
        tick(1);
        chk_en = 1'b1;
        tick(2);
        rst_N = 1'b1;
        tick(1);

        // 1: single estimate, two-cycle latency to the transfer edge
        clear_cap();
        s.m_ready = 1'b1;
        est = 32'h0000_1234; addr = 6'd5; data_valid = 1'b1;
        dv_cyc = cyc + 1;
        tick(1);
        data_valid = 1'b0;
        tick(5);
        check("t1_count", cap_q.size(), 1);
        if (cap_q.size() >= 1) begin
            check("t1_data", cap_q[0].data, 32'h0000_1234);
            check("t1_addr", cap_q[0].addr, 5);
            check("t1_tag", cap_q[0].tag, 2'b00);
            check("t1_last", cap_q[0].last, 1'b1);
            check("t1_latency", cap_cyc[0] - dv_cyc, 2);
        end

        // 2: nine back-to-back estimates while stalled -> overflow, first eight kept
        clear_cap();
        s.m_ready = 1'b0;
        for (int i = 0; i < 9; i++) begin
            est = DW'(32'h100 + i); addr = AW'(i); data_valid = 1'b1;
            tick(1);
        end
        data_valid = 1'b0;
        tick(2);
        check("t2_overflow", overflow, 1'b1);
        s.m_ready = 1'b1;
        tick(30);
        check("t2_count", cap_q.size(), 8);
        for (int i = 0; i < 8 && i < cap_q.size(); i++) begin
            check("t2_data", cap_q[i].data, 32'h100 + i);
            check("t2_addr", cap_q[i].addr, i);
        end

        // 3: weight dump, contiguous words with m_ready held high
        clear_cap();
        set_ramp();
        dump_req = 1'b1;
        tick(1);
        dump_req = 1'b0;
        tick(20);
        check("t3_count", cap_q.size(), FRAME_LEN);
        if (cap_q.size() == FRAME_LEN) begin
            check("t3_hdr", cap_q[0].data, 32'hA508_0000);
            check("t3_hdr_tag", cap_q[0].tag, 2'b01);
            for (int k = 1; k <= N_W; k++) begin
                check("t3_w", cap_q[k].data, k);
                check("t3_gap", cap_cyc[k] - cap_cyc[k-1], 1);
            end
            check("t3_last_pos", cap_q[FRAME_LEN-1].last, 1'b1);
            check("t3_w8_last", cap_q[N_W].last, !CK_EN);
            if (CK_EN) check("t3_cksum", cap_q[FRAME_LEN-1].data, 32'h0000_0008);
        end

        // 4: dump and estimate together; W_out changes mid-frame
        clear_cap();
        dump_req = 1'b1; data_valid = 1'b1; est = 32'hCAFE; addr = 6'd33;
        tick(1);
        dump_req = 1'b0; data_valid = 1'b0;
        tick(1);
        W_out = '1;
        tick(25);
        check("t4_count", cap_q.size(), FRAME_LEN + 1);
        if (cap_q.size() == FRAME_LEN + 1) begin
            check("t4_hdr_tag", cap_q[0].tag, 2'b01);
            check("t4_hdr_addr", cap_q[0].addr, 33);
            for (int k = 1; k <= N_W; k++) check("t4_old_w", cap_q[k].data, k);
            check("t4_est_tag", cap_q[FRAME_LEN].tag, 2'b00);
            check("t4_est_data", cap_q[FRAME_LEN].data, 32'hCAFE);
        end

        // 5: m_ready toggling every cycle during a dump
        clear_cap();
        set_ramp();
        dump_req = 1'b1;
        tick(1);
        dump_req = 1'b0;
        for (int i = 0; i < 40; i++) begin
            s.m_ready = i[0];
            tick(1);
        end
        s.m_ready = 1'b1;
        tick(3);
        check("t5_count", cap_q.size(), FRAME_LEN);
        if (cap_q.size() == FRAME_LEN) check("t5_w4", cap_q[4].data, 4);

        // 6: one-cycle reset mid-dump, then a fresh full frame
        dump_req = 1'b1;
        tick(1);
        dump_req = 1'b0;
        tick(3);
        rst_N = 1'b0;
        tick(1);
        rst_N = 1'b1;
        #1;
        check("t6_valid", s.m_valid, 1'b0);
        check("t6_busy", busy, 1'b0);
        check("t6_overflow", overflow, 1'b0);
        tick(2);
        clear_cap();
        dump_req = 1'b1;
        tick(1);
        dump_req = 1'b0;
        tick(20);
        check("t6_count", cap_q.size(), FRAME_LEN);
        if (cap_q.size() == FRAME_LEN) begin
            check("t6_hdr", cap_q[0].data, 32'hA508_0000);
            check("t6_last", cap_q[FRAME_LEN-1].last, 1'b1);
        end

        // Randomized traffic against the model
        for (int i = 0; i < 1500; i++) begin
            rst_N      = ($urandom_range(0, 299) != 0);
            ce         = ($urandom_range(0, 7) != 0);
            data_valid = ($urandom_range(0, 2) == 0);
            dump_req   = ($urandom_range(0, 15) == 0);
            s.m_ready  = ($urandom_range(0, 3) != 0);
            est        = $urandom;
            addr       = AW'($urandom);
            for (int k = 0; k < N_W; k++) W_out[k*DW +: DW] = $urandom;
            tick(1);
        end
        rst_N = 1'b1; data_valid = 1'b0; dump_req = 1'b0; s.m_ready = 1'b1;
        tick(60);
        check("drain_idle", busy, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
